// File: rtl/instruction_sequencer.sv
// Program buffer and fetch sequencer: loads a small program, then issues it one
// instruction per accepted valid/ready transfer. Define SEQ_LOOP_EN to wrap forever.
module instruction_sequencer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 26
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               stop,
  input  logic               ready_in,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [INSTR_W-1:0] instruction_q, instruction_d;
  logic               valid_q, valid_d;
  logic               mem_we;
  logic               at_last;

  logic [INSTR_W-1:0] mem_q [DEPTH];

  assign at_last = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));
  assign mem_we  = load_en && !stop && (state_q != RUN);

  always_comb begin
    // NOTE: every next-state variable gets a hold default first so no path infers a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    len_d         = len_q;
    instruction_d = instruction_q;
    valid_d       = valid_q;

    if (stop) begin
      state_d       = IDLE;
      pc_d          = '0;
      valid_d       = 1'b0;
      instruction_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start && !load_en && (prog_len != '0)) begin
            len_d         = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
            pc_d          = '0;
            instruction_d = mem_q[0];
            valid_d       = 1'b1;
            state_d       = RUN;
          end
        end
        RUN: begin
          if (valid_q && ready_in) begin
            if (!at_last) begin
              pc_d          = pc_q + ADDR_W'(1);
              instruction_d = mem_q[pc_q + ADDR_W'(1)];
            end else begin
`ifdef SEQ_LOOP_EN
              pc_d          = '0;
              instruction_d = mem_q[0];
`else
              state_d       = DONE;
              valid_d       = 1'b0;
              instruction_d = '0;
`endif
            end
          end
        end
        default: begin
          state_d       = IDLE;
          pc_d          = '0;
          valid_d       = 1'b0;
          instruction_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      len_q         <= '0;
      instruction_q <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      len_q         <= len_d;
      instruction_q <= instruction_d;
      valid_q       <= valid_d;
    end
  end

  // NOTE: the program memory is deliberately not reset so a program survives reset_n.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[load_addr] <= load_data;
  end

  assign instruction = instruction_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program buffer and fetch sequencer feeding the 26-bit instruction input of the 8-bit ALU/register-file datapath. Holds a small loadable program, then issues it one instruction per accepted cycle under a valid/ready handshake. Sits directly upstream of the ALU stage, which ties `ready_in` high or stalls it.

## Interface
- `DEPTH`, 16: program memory words, power of two, 2..256
- `ADDR_W`, 4: address width, equals log2(`DEPTH`)
- `INSTR_W`, 26: instruction width; matches the ALU stage instruction port
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `load_en`  in  1  write `load_data` into memory at `load_addr`
- `load_addr`  in  ADDR_W  program write address
- `load_data`  in  INSTR_W  program write data
- `start`  in  1  begin issuing program from address 0
- `prog_len`  in  ADDR_W+1  number of instructions to issue, sampled on accepted `start`
- `stop`  in  1  abort and return to IDLE
- `ready_in`  in  1  downstream accepts current instruction
- `instruction`  out  INSTR_W  registered instruction to ALU stage
- `instr_valid`  out  1  `instruction` is valid
- `pc`  out  ADDR_W  address of instruction currently presented
- `busy`  out  1  state is RUN
- `done`  out  1  state is DONE

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- Memory: DEPTH x INSTR_W, not reset. Writes only in IDLE or DONE; `load_en` in RUN is ignored.
- Length latch: `len` <= min(`prog_len`, DEPTH) on accepted start.
- IDLE/DONE + `start` + !`load_en` + `prog_len` != 0: `pc`<=0, `instruction`<=mem[0], `instr_valid`<=1, -> RUN.
- `start` with `prog_len`==0 or with `load_en` high: ignored, state unchanged.
- RUN, transfer (`instr_valid` & `ready_in`):
  - `pc` < `len`-1: `pc`<=`pc`+1, `instruction`<=mem[`pc`+1].
  - `pc` == `len`-1: -> DONE, `instr_valid`<=0, `instruction`<=0, `pc` holds.
- RUN, `ready_in` low: all outputs hold (instruction stable while valid).
- `start` in RUN: ignored.
- `stop` (any state): highest priority over start, load and transfer; -> IDLE, `pc`<=0, `instr_valid`<=0, `instruction`<=0. Load in the same cycle as `stop` is discarded.
- Loading address k in DONE then restarting issues the new word at k.

## Timing
- Reset values: `instruction`=0, `instr_valid`=0, `pc`=0, `busy`=0, `done`=0, state IDLE, `len`=0.
- Start latency: `start` sampled at edge N -> `instr_valid`=1 with mem[0] after edge N.
- Throughput: one instruction per cycle with `ready_in` held high; program of L words issues on L consecutive cycles, `done`=1 from the edge after the last transfer.
- Memory write at edge N readable by a `start` at edge N+1.
- `busy`, `done` decoded from state register (registered, no comb path from inputs).
- Reset asserted mid-RUN: outputs return to reset values immediately (asynchronous); memory contents retained.

## Configuration
- `SEQ_LOOP_EN` defined: in RUN, transfer at `pc`==`len`-1 wraps to `pc`<=0, `instruction`<=mem[0], valid stays 1, state stays RUN; DONE is unreachable and only `stop` or reset ends the program.
- Not defined: behaviour as in Operation (terminate to DONE after `len` transfers).

## Test plan
- Reset: `reset_n`=0 mid-RUN -> `instr_valid`=0, `pc`=0, `instruction`=0, `busy`=0 without clock edge.
- Load mem[0..2]=26'h0000001, 26'h36E3200, 26'h3FFFFFF, `start` with `prog_len`=3, `ready_in`=1 -> three consecutive valid cycles with those words, `pc` 0,1,2, then `done`=1, `instr_valid`=0.
- Same program, `ready_in` low for 4 cycles while `pc`=1 -> `instruction`=26'h36E3200 held for 5 cycles, total 7 valid cycles.
- `prog_len`=0 -> stays IDLE; `prog_len`=31 with DEPTH=16 -> exactly 16 transfers; `load_en` during RUN -> memory unchanged on rerun.
- `stop` asserted together with `ready_in` at `pc`=1 -> next cycle IDLE, `pc`=0, `instr_valid`=0; `start` with `load_en` -> ignored.
- `SEQ_LOOP_EN` build, `prog_len`=2 -> `pc` sequence 0,1,0,1,0 with `instr_valid` constant 1, `done` never asserts until `stop`.
